// File: rtl/audio_fade_fifo.sv
// Sample FIFO between the sound readers and the audio codec, applying a
// ramped volume/mute gain and writing silence when the codec finds it empty.
module audio_fade_fifo #(
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 8,
    parameter int RAMP_DIV = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic [4:0]        volume,
    input  logic              mute,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic [AW:0]       fifo_count,
    output logic [15:0]       underrun_count,
    output logic [4:0]        gain
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PW    = DATA_W + 4;

    logic [DATA_W-1:0] r_mem_l [DEPTH];
    logic [DATA_W-1:0] r_mem_r [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_write;
    logic [DATA_W-1:0] r_wd_l;
    logic [DATA_W-1:0] r_wd_r;
    logic [15:0]       r_underrun;
    logic [4:0]        r_gain;
    logic [DIV_W-1:0]  r_div;

    logic              w_push;
    logic              w_wr_edge;
    logic              w_pop;
    logic [4:0]        w_target;
    logic signed [PW-1:0] w_prod_l;
    logic signed [PW-1:0] w_prod_r;
    logic signed [PW-1:0] w_gain_ext;

    assign in_ready  = (r_count != (AW+1)'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_wr_edge = write_ready && !r_write;
    assign w_pop     = w_wr_edge && (r_count != '0);
    assign w_target  = mute ? 5'd0 : ((volume > 5'd16) ? 5'd16 : volume);

    // Product fits in DATA_W+4 bits since gain <= 16; the >>>4 is a bit slice.
    assign w_gain_ext = $signed({{(PW-5){1'b0}}, r_gain});
    assign w_prod_l   = $signed({{4{r_mem_l[r_rptr][DATA_W-1]}}, r_mem_l[r_rptr]}) * w_gain_ext;
    assign w_prod_r   = $signed({{4{r_mem_r[r_rptr][DATA_W-1]}}, r_mem_r[r_rptr]}) * w_gain_ext;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wptr] <= in_left;
            r_mem_r[r_wptr] <= in_right;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_write    <= 1'b0;
            r_wd_l     <= '0;
            r_wd_r     <= '0;
            r_underrun <= '0;
            r_gain     <= '0;
            r_div      <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_write <= w_wr_edge;
            if (w_wr_edge) begin
                if (w_pop) begin
                    r_wd_l <= w_prod_l[PW-1:4];
                    r_wd_r <= w_prod_r[PW-1:4];
                end else begin
                    r_wd_l <= '0;
                    r_wd_r <= '0;
                    if (r_underrun != 16'hFFFF)
                        r_underrun <= r_underrun + 16'd1;
                end

                if (r_div == DIV_W'(RAMP_DIV - 1)) begin
                    r_div <= '0;
                    if (r_gain < w_target)
                        r_gain <= r_gain + 5'd1;
                    else if (r_gain > w_target)
                        r_gain <= r_gain - 5'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign write           = r_write;
    assign writedata_left  = r_wd_l;
    assign writedata_right = r_wd_r;
    assign fifo_count      = r_count;
    assign underrun_count  = r_underrun;
    assign gain            = r_gain;
endmodule

// File: tb/tb_audio_fade_fifo.sv
// Randomized bench for audio_fade_fifo against a queue-based reference of the
// buffer, the write pacing and the gain ramp.
module tb_audio_fade_fifo;
    localparam int DATA_W   = 24;
    localparam int DEPTH    = 8;
    localparam int RAMP_DIV = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic [4:0]        volume;
    logic              mute;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic [3:0]        fifo_count;
    logic [15:0]       underrun_count;
    logic [4:0]        gain;

    int n_vec = 0;
    int n_err = 0;

    logic [2*DATA_W-1:0] m_q[$];
    bit                  m_write;
    logic [DATA_W-1:0]   m_wl, m_wr;
    int                  m_underrun, m_gain, m_writes;

    audio_fade_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RAMP_DIV(RAMP_DIV)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .volume(volume), .mute(mute),
        .write_ready(write_ready), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .fifo_count(fifo_count), .underrun_count(underrun_count), .gain(gain)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gain scaling as floor(sample * g / 16) on plain integers.
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s, input int g);
        int sv;
        int p;
        logic [31:0] r;
        sv = $signed(s);
        p  = sv * g;
        if (p >= 0) p = p / 16;
        else        p = -((-p + 15) / 16);
        r = p;
        return r[DATA_W-1:0];
    endfunction

    task automatic model_update();
        bit push;
        logic [2*DATA_W-1:0] e;
        int tgt;
        if (reset) begin
            m_q.delete();
            m_write = 0; m_wl = '0; m_wr = '0;
            m_underrun = 0; m_gain = 0; m_writes = 0;
            return;
        end
        push = in_valid && (m_q.size() < DEPTH);
        e    = {in_left, in_right};
        if (write_ready && !m_write) begin
            if (m_q.size() > 0) begin
                logic [2*DATA_W-1:0] h;
                h = m_q.pop_front();
                m_wl = scale(h[2*DATA_W-1:DATA_W], m_gain);
                m_wr = scale(h[DATA_W-1:0], m_gain);
            end else begin
                m_wl = '0; m_wr = '0;
                if (m_underrun < 65535) m_underrun++;
            end
            m_writes++;
            if (m_writes % RAMP_DIV == 0) begin
                tgt = mute ? 0 : ((volume > 16) ? 16 : int'(volume));
                if (m_gain < tgt) m_gain++;
                else if (m_gain > tgt) m_gain--;
            end
            m_write = 1;
        end else begin
            m_write = 0;
        end
        if (push) m_q.push_back(e);
    endtask

    task automatic compare_all();
        check_eq("write", 32'(write), 32'(m_write));
        check_eq("wd_left", 32'(writedata_left), 32'(m_wl));
        check_eq("wd_right", 32'(writedata_right), 32'(m_wr));
        check_eq("fifo_count", 32'(fifo_count), m_q.size());
        check_eq("underrun", 32'(underrun_count), m_underrun);
        check_eq("gain", 32'(gain), m_gain);
        check_eq("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_gain(input int g, input int max_cycles);
        for (int i = 0; i < max_cycles && m_gain != g; i++) step();
        check_eq("gain_reached", 32'(gain), g);
    endtask

    task automatic wait_write(input string tag);
        int k;
        k = 0;
        while (write !== 1'b1 && k < 20) begin step(); k++; end
        if (k >= 20) check_eq({tag, "_timeout"}, 32'(write), 1);
    endtask

    initial begin
        reset = 1; in_valid = 0; in_left = '0; in_right = '0;
        volume = 5'd16; mute = 0; write_ready = 0;
        @(negedge clk);
        step(); step();
        check_eq("rst_count", 32'(fifo_count), 0);
        check_eq("rst_write", 32'(write), 0);
        check_eq("rst_gain", 32'(gain), 0);
        reset = 0;
        step();
        check_eq("rst_in_ready", 32'(in_ready), 1);

        // Idle codec traffic: silence writes and the first fade-in step.
        write_ready = 1;
        for (int i = 0; i < 200; i++) step();
        run_to_gain(16, 2400);

        // Full-scale extremes must pass unchanged at unity gain.
        write_ready = 0; in_valid = 1; in_left = 24'h7FFFFF; in_right = 24'h800000;
        step();
        in_valid = 0; step();
        write_ready = 1;
        wait_write("unity");
        check_eq("unity_left", 32'(writedata_left), 32'h7FFFFF);
        check_eq("unity_right", 32'(writedata_right), 32'h800000);

        // Half gain, odd magnitudes exercise the floor on negatives.
        volume = 5'd8;
        run_to_gain(8, 1400);
        write_ready = 0; in_valid = 1; in_left = 24'h000003; in_right = 24'hFFFFFD;
        step();
        in_valid = 0; step();
        write_ready = 1;
        wait_write("half");
        check_eq("half_left", 32'(writedata_left), 32'h000001);
        check_eq("half_right", 32'(writedata_right), 32'hFFFFFE);

        // Fill past capacity while the codec is stalled.
        write_ready = 0; step(); step();
        in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            in_left = 24'(32'h100 + i); in_right = 24'(32'hFFF000 - i);
            step();
        end
        check_eq("full_in_ready", 32'(in_ready), 0);
        check_eq("full_count", 32'(fifo_count), 8);
        in_valid = 0; write_ready = 1;
        step();
        check_eq("pop_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 20; i++) step();

        // Mute fade-out, then release mid-ramp.
        volume = 5'd16;
        run_to_gain(16, 1400);
        mute = 1;
        run_to_gain(10, 1000);
        mute = 0;
        for (int i = 0; i < 300; i++) step();
        check_eq("unmute_rise", 32'(gain), 12);

        // Random traffic including out-of-range volume and mute toggles.
        for (int i = 0; i < 4000; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            write_ready = ($urandom_range(0, 2) != 0);
            in_left     = 24'($urandom);
            in_right    = 24'($urandom);
            if ($urandom_range(0, 199) == 0) volume = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) mute = ~mute;
            step();
        end

        // Reset with data buffered and a write just issued.
        in_valid = 0; write_ready = 0; step(); step();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_left = 24'($urandom); in_right = 24'($urandom);
            step();
        end
        in_valid = 0; write_ready = 1;
        step();
        reset = 1;
        step();
        check_eq("mid_rst_count", 32'(fifo_count), 0);
        check_eq("mid_rst_write", 32'(write), 0);
        check_eq("mid_rst_gain", 32'(gain), 0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 1);
        reset = 0; write_ready = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
